// File: rtl/bexkat2_bus_target.sv
`default_nettype none
// ============================================================================
// Module      : bexkat2_bus_target
// Description : Word-addressed RAM responder for the bexkat2 CPU bus with
//               programmable wait states and an error response past LIMIT.
//               Define BEXKAT2_BUSTGT_BYTESEL_EN to honour sel_i on writes.
// Revision    : 1.0 - initial release
// ============================================================================
module bexkat2_bus_target #(
    parameter int AW    = 10,
    parameter int LIMIT = 2**AW,
    parameter int WAIT  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [AW-1:0] adr_i,
    input  logic [3:0]    sel_i,
    input  logic [31:0]   dat_i,
    output logic [31:0]   dat_o,
    output logic          ack_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          c_DEPTH    = 2**AW;
    localparam logic [3:0]  c_WAIT_CNT = 4'(WAIT);
    localparam logic [AW:0] c_LIMIT    = (AW+1)'(LIMIT);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdat_q;
    logic [31:0]   dat_q;
    logic          ack_q;
    logic          err_q;

    logic [31:0]   mem_q [c_DEPTH];

    logic          w_in_range;
    logic          w_mem_we;
    logic [3:0]    w_lane_en;

    assign w_in_range = ({1'b0, adr_q} < c_LIMIT);

`ifdef BEXKAT2_BUSTGT_BYTESEL_EN
    assign w_lane_en = sel_q;
`else
    logic w_unused_sel;
    assign w_lane_en    = 4'hF;
    assign w_unused_sel = ^sel_q;
`endif

    // Reset on the write edge wins, so a write in S_RESP is dropped with it.
    assign w_mem_we = (state_q == S_RESP) && cyc_i && we_q && w_in_range && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            wdat_q  <= 32'd0;
            dat_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (cyc_i && stb_i) begin
                        adr_q   <= adr_i;
                        we_q    <= we_i;
                        sel_q   <= sel_i;
                        wdat_q  <= dat_i;
                        cnt_q   <= c_WAIT_CNT;
                        state_q <= (c_WAIT_CNT != 4'd0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!cyc_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    // Termination is registered: it shows in the following S_IDLE cycle.
                    if (cyc_i) begin
                        if (w_in_range) begin
                            ack_q <= 1'b1;
                            if (!we_q) begin
                                dat_q <= mem_q[adr_q];
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lane_en[b]) begin
                    mem_q[adr_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bexkat2_bus_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_bexkat2_bus_target
// Description : Directed bench for bexkat2_bus_target using three instances
//               (WAIT=1/LIMIT=512, WAIT=3, WAIT=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bexkat2_bus_target;

`ifdef BEXKAT2_BUSTGT_BYTESEL_EN
    localparam logic [31:0] c_SEL_EXP = 32'h11BB33DD;
`else
    localparam logic [31:0] c_SEL_EXP = 32'hAABBCCDD;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic [2:0]  we;
    logic [9:0]  adr  [3];
    logic [3:0]  sel  [3];
    logic [31:0] wdat [3];

    logic [31:0] rdat0, rdat1, rdat2;
    logic        ack0, ack1, ack2, err0, err1, err2;
    logic [31:0] rdat [3];
    logic [2:0]  ack;
    logic [2:0]  err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign ack = {ack2, ack1, ack0};
    assign err = {err2, err1, err0};
    assign rdat[0] = rdat0;
    assign rdat[1] = rdat1;
    assign rdat[2] = rdat2;

    bexkat2_bus_target #(.AW(10), .LIMIT(512), .WAIT(1)) u_dut_w1 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .adr_i(adr[0]), .sel_i(sel[0]), .dat_i(wdat[0]),
        .dat_o(rdat0), .ack_o(ack0), .err_o(err0)
    );

    bexkat2_bus_target #(.AW(10), .WAIT(3)) u_dut_w3 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .adr_i(adr[1]), .sel_i(sel[1]), .dat_i(wdat[1]),
        .dat_o(rdat1), .ack_o(ack1), .err_o(err1)
    );

    bexkat2_bus_target #(.AW(10), .WAIT(0)) u_dut_w0 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
        .adr_i(adr[2]), .sel_i(sel[2]), .dat_i(wdat[2]),
        .dat_o(rdat2), .ack_o(ack2), .err_o(err2)
    );

    typedef struct {
        int          k;
        logic        w;
        logic [9:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer; stb/cyc drop in the termination cycle.
    task automatic xfer(input int k, input logic w, input logic [9:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic got_ack, output logic got_err,
                        output logic [31:0] got_dat, output int lat);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; wdat[k] = d;
        got_ack = 1'b0; got_err = 1'b0; got_dat = 32'd0; lat = -1;
        @(posedge clk);
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) begin
                got_ack = ack[k]; got_err = err[k]; got_dat = rdat[k]; lat = j;
                break;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("pulse_end_k%0d", k), {30'd0, ack[k], err[k]}, 32'd0);
    endtask

    task automatic watch_quiet(input int k, input string name);
        logic seen;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    vec_t        vecs [13];
    logic        g_ack, g_err;
    logic [31:0] g_dat;
    int          g_lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = '0; stb = '0; we = '0;
        for (int k = 0; k < 3; k++) begin
            adr[k] = '0; sel[k] = 4'hF; wdat[k] = '0;
        end

        vecs[0]  = '{0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        2};
        vecs[1]  = '{0, 1'b0, 10'h010, 4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 2};
        vecs[2]  = '{0, 1'b1, 10'h020, 4'hF, 32'h11223344, 1'b1, 1'b0, 32'h0,        2};
        vecs[3]  = '{0, 1'b1, 10'h020, 4'h5, 32'hAABBCCDD, 1'b1, 1'b0, 32'h0,        2};
        vecs[4]  = '{0, 1'b0, 10'h020, 4'hF, 32'h0,        1'b1, 1'b0, c_SEL_EXP,    2};
        vecs[5]  = '{0, 1'b1, 10'h200, 4'hF, 32'h12345678, 1'b0, 1'b1, 32'h0,        2};
        vecs[6]  = '{0, 1'b1, 10'h1FF, 4'hF, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h0,        2};
        vecs[7]  = '{0, 1'b0, 10'h1FF, 4'hF, 32'h0,        1'b1, 1'b0, 32'h0F0F0F0F, 2};
        vecs[8]  = '{0, 1'b0, 10'h3FF, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0,        2};
        vecs[9]  = '{1, 1'b1, 10'h030, 4'hF, 32'h55AA55AA, 1'b1, 1'b0, 32'h0,        4};
        vecs[10] = '{1, 1'b1, 10'h040, 4'hF, 32'h600DCAFE, 1'b1, 1'b0, 32'h0,        4};
        vecs[11] = '{2, 1'b1, 10'h001, 4'hF, 32'hA1A1A1A1, 1'b1, 1'b0, 32'h0,        1};
        vecs[12] = '{2, 1'b1, 10'h002, 4'hF, 32'hB2B2B2B2, 1'b1, 1'b0, 32'h0,        1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_k%0d", k), {rdat[k][31:2], rdat[k][1] | ack[k], rdat[k][0] | err[k]}, 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, g_ack, g_err, g_dat, g_lat);
            chk($sformatf("v%0d_ack", i), {31'd0, g_ack}, {31'd0, vecs[i].exp_ack});
            chk($sformatf("v%0d_err", i), {31'd0, g_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_dat", i), g_dat, vecs[i].exp_dat);
            chk($sformatf("v%0d_lat", i), 32'(g_lat), 32'(vecs[i].exp_lat));
        end

        // Back-to-back reads on the WAIT=0 instance: next request presented in the ack cycle.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 10'h001;
        @(posedge clk);
        @(posedge clk); #1;
        chk("b2b_ack1", {31'd0, ack[2]}, 32'd1);
        chk("b2b_dat1", rdat[2], 32'hA1A1A1A1);
        adr[2] = 10'h002;
        @(posedge clk); #1;
        chk("b2b_gap", {31'd0, ack[2]}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_ack2", {31'd0, ack[2]}, 32'd1);
        chk("b2b_dat2", rdat[2], 32'hB2B2B2B2);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end", {30'd0, ack[2], err[2]}, 32'd0);

        // Abort: cyc dropped one cycle after acceptance on the WAIT=3 instance.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 10'h030; wdat[1] = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        watch_quiet(1, "abort_no_term");
        xfer(1, 1'b0, 10'h030, 4'hF, 32'h0, g_ack, g_err, g_dat, g_lat);
        chk("abort_rd_ack", {31'd0, g_ack}, 32'd1);
        chk("abort_rd_dat", g_dat, 32'h55AA55AA);

        // Reset while in S_WAIT.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 10'h040; wdat[1] = 32'h0BADF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        chk("rstw_outs", {rdat[1][31:2], rdat[1][1] | ack[1], rdat[1][0] | err[1]}, 32'd0);
        watch_quiet(1, "rstw_no_term");
        xfer(1, 1'b0, 10'h040, 4'hF, 32'h0, g_ack, g_err, g_dat, g_lat);
        chk("rstw_rd_dat", g_dat, 32'h600DCAFE);
        chk("rstw_rd_lat", 32'(g_lat), 32'd4);

        // Reset on the edge that would commit a write from S_RESP (WAIT=0).
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 10'h050; wdat[2] = 32'hFFFFFFFF;
        xfer(2, 1'b1, 10'h050, 4'hF, 32'h13572468, g_ack, g_err, g_dat, g_lat);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 10'h050; wdat[2] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        chk("rstr_outs", {30'd0, ack[2], err[2]}, 32'd0);
        xfer(2, 1'b0, 10'h050, 4'hF, 32'h0, g_ack, g_err, g_dat, g_lat);
        chk("rstr_rd_dat", g_dat, 32'h13572468);
        chk("rstr_rd_lat", 32'(g_lat), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
